// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared helpers and defaults for the scan shadow bank
package scan_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NUM_CH = 2;
  localparam logic [63:0] DEF_RESET_VAL = '0;

  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

  // Low bit index of channel c inside a packed NUM_CH*WIDTH vector.
  function automatic int ch_lo(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/scan_shadow_bank_if.sv
// rtl/scan_shadow_bank_if.sv - scan chain / shadow bus between scan generator and bank
interface scan_shadow_bank_if
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH
) ();

  localparam int TOTAL = WIDTH * NUM_CH;
  localparam int CNT_W = cnt_width(TOTAL);

  logic              io_scan_en;
  logic              io_scan_in;
  logic              io_scan_out;
  logic              io_capture;
  logic              io_update;
  logic [NUM_CH-1:0] io_lock;
  logic [TOTAL-1:0]  io_d;
  logic [TOTAL-1:0]  io_q;
  logic [CNT_W-1:0]  io_shift_cnt;
  logic              io_full;

  modport master (
    output io_scan_en, io_scan_in, io_capture, io_update, io_lock, io_d,
    input  io_scan_out, io_q, io_shift_cnt, io_full
  );

  modport slave (
    input  io_scan_en, io_scan_in, io_capture, io_update, io_lock, io_d,
    output io_scan_out, io_q, io_shift_cnt, io_full
  );

endinterface

// File: rtl/scan_shadow_ch.sv
// rtl/scan_shadow_ch.sv - one lockable shadow channel with its own reset value
module scan_shadow_ch #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update,
  input  logic             lock,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (update && !lock) begin
      q <= d;
    end
  end

endmodule

// File: rtl/scan_shadow_bank.sv
// rtl/scan_shadow_bank.sv - serial scan chain with capture, shift counter and lockable shadow bank
module scan_shadow_bank
  import scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter logic [WIDTH*NUM_CH-1:0] RESET_VAL = (WIDTH*NUM_CH)'(DEF_RESET_VAL)
) (
  input  logic               io_clk,
  input  logic               io_rst_n,
  scan_shadow_bank_if.slave  bus
);

  localparam int TOTAL = WIDTH * NUM_CH;
  localparam int CNT_W = cnt_width(TOTAL);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL);

  logic [TOTAL-1:0] shift_reg;
  logic [TOTAL-1:0] shadow;
  logic [CNT_W-1:0] cnt;

  // Capture wins over shift; update only clears the counter when neither acts.
  always_ff @(posedge io_clk) begin
    if (!io_rst_n) begin
      shift_reg <= RESET_VAL;
      cnt       <= '0;
    end else if (bus.io_capture) begin
      shift_reg <= bus.io_d;
      cnt       <= '0;
    end else if (bus.io_scan_en) begin
      shift_reg <= {bus.io_scan_in, shift_reg[TOTAL-1:1]};
      cnt       <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end else if (bus.io_update) begin
      cnt       <= '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    scan_shadow_ch #(
      .WIDTH   (WIDTH),
      .RST_VAL (RESET_VAL[ch_lo(c, WIDTH) +: WIDTH])
    ) u_ch (
      .clk    (io_clk),
      .rst_n  (io_rst_n),
      .update (bus.io_update),
      .lock   (bus.io_lock[c]),
      .d      (shift_reg[ch_lo(c, WIDTH) +: WIDTH]),
      .q      (shadow[ch_lo(c, WIDTH) +: WIDTH])
    );
  end

  assign bus.io_q         = shadow;
  assign bus.io_scan_out  = shift_reg[0];
  assign bus.io_shift_cnt = cnt;
  assign bus.io_full      = (cnt == CNT_MAX);

endmodule

// File: tb/tb_scan_shadow_bank.sv
// tb/tb_scan_shadow_bank.sv - table-driven scoreboard bench for scan_shadow_bank
module tb_scan_shadow_bank;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic       si;
    logic       cap;
    logic       upd;
    logic [1:0] lock;
    logic [7:0] d;
    logic [7:0] q;
    logic       so;
    logic [3:0] cnt;
    logic       full;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       so;
    logic [3:0] cnt;
    logic       full;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  scan_shadow_bank_if #(.WIDTH(4), .NUM_CH(2)) bus ();

  scan_shadow_bank #(
    .WIDTH     (4),
    .NUM_CH    (2),
    .RESET_VAL (8'hA5)
  ) dut (
    .io_clk   (clk),
    .io_rst_n (rst_n),
    .bus      (bus.slave)
  );

  function automatic vec_t mk(string name, logic r, logic en, logic si, logic cap, logic upd,
                              logic [1:0] lock, logic [7:0] d, logic [7:0] q, logic so,
                              logic [3:0] cnt, logic full);
    vec_t v;
    v.name = name; v.rst_n = r; v.en = en; v.si = si; v.cap = cap; v.upd = upd;
    v.lock = lock; v.d = d; v.q = q; v.so = so; v.cnt = cnt; v.full = full;
    return v;
  endfunction

  task automatic chk(string name, string field, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got %h expected %h", name, field, got, want);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    rst_n          = v.rst_n;
    bus.io_scan_en = v.en;
    bus.io_scan_in = v.si;
    bus.io_capture = v.cap;
    bus.io_update  = v.upd;
    bus.io_lock    = v.lock;
    bus.io_d       = v.d;
    e.name = v.name; e.q = v.q; e.so = v.so; e.cnt = v.cnt; e.full = v.full;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.name, "q", bus.io_q, e.q);
    chk(e.name, "scan_out", {7'd0, bus.io_scan_out}, {7'd0, e.so});
    chk(e.name, "shift_cnt", {4'd0, bus.io_shift_cnt}, {4'd0, e.cnt});
    chk(e.name, "full", {7'd0, bus.io_full}, {7'd0, e.full});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b3c;
    logic [7:0] so_t2;
    logic [7:0] so_t3;
    logic [7:0] so_t4;
    logic [11:0] so_t6;
    b3c   = 8'h3C;
    so_t2 = 8'b0101_0010;   // scan_out after shifts 1..8, bit k-1 = shift k
    so_t3 = 8'b1101_0010;
    so_t4 = 8'b0100_1011;
    so_t6 = 12'b0000_0100_0011;

    rst_n = 1'b0;
    bus.io_scan_en = 1'b0; bus.io_scan_in = 1'b0; bus.io_capture = 1'b0;
    bus.io_update = 1'b0; bus.io_lock = 2'b00; bus.io_d = 8'h00;

    for (int i = 0; i < 2; i++)
      tbl.push_back(mk("t1_reset", 0, 1, 1, 0, 1, 2'b00, 8'h00, 8'hA5, 1, 4'd0, 0));

    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk($sformatf("t2_shift%0d", k), 1, 1, b3c[k-1], 0, 0, 2'b00, 8'h00,
                       8'hA5, so_t2[k-1], 4'(k), k == 8));
    tbl.push_back(mk("t2_update", 1, 0, 0, 0, 1, 2'b00, 8'h00, 8'h3C, 0, 4'd0, 0));

    tbl.push_back(mk("t3_reset", 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'hA5, 1, 4'd0, 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk($sformatf("t3_shift%0d", k), 1, 1, 1, 0, 0, 2'b10, 8'h00,
                       8'hA5, so_t3[k-1], 4'(k), k == 8));
    tbl.push_back(mk("t3_lock_update", 1, 0, 0, 0, 1, 2'b10, 8'h00, 8'hAF, 1, 4'd0, 0));

    tbl.push_back(mk("t4_capture", 1, 1, 1, 1, 0, 2'b00, 8'h96, 8'hAF, 0, 4'd0, 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk($sformatf("t4_shiftout%0d", k), 1, 1, 0, 0, 0, 2'b00, 8'h00,
                       8'hAF, so_t4[k-1], 4'(k), k == 8));

    tbl.push_back(mk("t5_capture", 1, 0, 0, 1, 0, 2'b00, 8'h0F, 8'hAF, 1, 4'd0, 0));
    tbl.push_back(mk("t5_upd_shift", 1, 1, 1, 0, 1, 2'b00, 8'h00, 8'h0F, 1, 4'd1, 0));
    tbl.push_back(mk("t5_upd_check", 1, 0, 0, 0, 1, 2'b00, 8'h00, 8'h87, 1, 4'd0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Saturation: counter sticks at 8 while data keeps moving through the chain.
    for (int k = 1; k <= 12; k++)
      apply(mk($sformatf("t6_sat%0d", k), 1, 1, 0, 0, 0, 2'b00, 8'h00, 8'h87,
               so_t6[k-1], (k >= 8) ? 4'd8 : 4'(k), k >= 8));
    for (int k = 1; k <= 3; k++)
      apply(mk($sformatf("t6_more%0d", k), 1, 1, 1, 0, 0, 2'b00, 8'h00, 8'h87, 0, 4'd8, 1));
    apply(mk("t6_mid_reset", 0, 1, 1, 0, 0, 2'b00, 8'h00, 8'hA5, 1, 4'd0, 0));
    apply(mk("t6_post_shift", 1, 1, 0, 0, 0, 2'b00, 8'h00, 8'hA5, 0, 4'd1, 0));
    apply(mk("t6_post_update", 1, 0, 0, 0, 1, 2'b00, 8'h00, 8'h52, 0, 4'd0, 0));
    apply(mk("t6_idle", 1, 0, 1, 0, 0, 2'b11, 8'hFF, 8'h52, 0, 4'd0, 0));

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
